// File: rtl/cpu_pkg.sv
// Shared core definitions: the 7-bit op encoding used by ALU, decoder and
// the HI/LO unit, plus the mult/div sequencer states.
package cpu_pkg;

    localparam int unsigned OP_W = 7;

    typedef enum logic [OP_W-1:0] {
        OP_DIV   = 7'd7,
        OP_DIVU  = 7'd8,
        OP_MTHI  = 7'd11,
        OP_MTLO  = 7'd12,
        OP_MULT  = 7'd13,
        OP_MULTU = 7'd14
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2
    } muldiv_state_t;

    // True for the four ops that run through the iterative sequencer.
    function automatic logic is_muldiv_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Final sign correction of the unsigned iteration result into HI/LO.
module muldiv_fixup
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic               is_div,
    input  logic               div0,
    output logic [WIDTH-1:0]   hi_c,
    output logic [WIDTH-1:0]   lo_c
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc : acc;
        quot = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        hi_c = prod[2*WIDTH-1:WIDTH];
        lo_c = prod[WIDTH-1:0];
        if (is_div) begin
            // Divide by zero keeps the all-ones quotient regardless of signs.
            lo_c = ((sign_a ^ sign_b) && !div0) ? -quot : quot;
            hi_c = sign_a ? -rem : rem;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO unit: iterative shift-add multiply and restoring divide,
// plus single-cycle MTHI/MTLO, owning the architectural HI/LO registers.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [ACC_W-1:0] acc_q;
    logic             sign_a_q, sign_b_q, is_div_q, div0_q;
    logic             busy_q, ready_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             accept_c, start_c, wr_hi_c, wr_lo_c, step_c, fix_c;
    logic             signed_c;
    logic [WIDTH-1:0] fix_hi_c, fix_lo_c;

    logic [WIDTH:0]   mul_sum_c;
    logic [ACC_W-1:0] mul_next_c;
    logic [WIDTH:0]   div_shift_c, div_diff_c;
    logic             div_ge_c;
    logic [WIDTH-1:0] div_rem_c;
    logic [ACC_W-1:0] div_next_c;

    assign accept_c = req_valid && ready_q;
    assign signed_c = is_signed_op(op);

    // Sequencer next state and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        wr_hi_c = 1'b0;
        wr_lo_c = 1'b0;
        step_c  = 1'b0;
        fix_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (is_muldiv_op(op)) begin
                        start_c = 1'b1;
                        state_d = ITER;
                    end
                    wr_hi_c = (op == OP_MTHI);
                    wr_lo_c = (op == OP_MTLO);
                end
            end
            ITER: begin
                step_c = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                fix_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, (opb_q[0] ? opa_q : '0)};
        mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};
    end

    // Divide step: remainder in the upper half, quotient bits enter at bit 0.
    always_comb begin
        div_shift_c = {acc_q[ACC_W-1:WIDTH], opa_q[WIDTH-1]};
        div_diff_c  = div_shift_c - {1'b0, opb_q};
        div_ge_c    = (div_shift_c >= {1'b0, opb_q});
        div_rem_c   = div_ge_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
        div_next_c  = {div_rem_c, acc_q[WIDTH-2:0], div_ge_c};
    end

    muldiv_fixup #(
        .WIDTH (WIDTH)
    ) u_fixup (
        .acc    (acc_q),
        .sign_a (sign_a_q),
        .sign_b (sign_b_q),
        .is_div (is_div_q),
        .div0   (div0_q),
        .hi_c   (fix_hi_c),
        .lo_c   (fix_lo_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= fix_c;
            if (start_c) begin
                opa_q    <= (signed_c && a[WIDTH-1]) ? -a : a;
                opb_q    <= (signed_c && b[WIDTH-1]) ? -b : b;
                sign_a_q <= signed_c && a[WIDTH-1];
                sign_b_q <= signed_c && b[WIDTH-1];
                is_div_q <= (op == OP_DIV) || (op == OP_DIVU);
                div0_q   <= (b == '0);
                acc_q    <= '0;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                ready_q  <= 1'b0;
            end
            if (step_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    acc_q <= div_next_c;
                    opa_q <= {opa_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_q <= mul_next_c;
                    opb_q <= {1'b0, opb_q[WIDTH-1:1]};
                end
            end
            if (fix_c) begin
                hi_q    <= fix_hi_c;
                lo_q    <= fix_lo_c;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
            end
            if (wr_hi_c) begin
                hi_q <= a;
            end
            if (wr_lo_c) begin
                lo_q <= a;
            end
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: architectural HI/LO result straight from integer arithmetic.
    function automatic void model(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        longint      sx, sy;
        int          ix, iy;
        eh = 32'h0;
        el = 32'h0;
        case (o)
            OP_MULTU: begin
                p  = {32'h0, x} * {32'h0, y};
                eh = p[63:32];
                el = p[31:0];
            end
            OP_MULT: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = 64'(sx * sy);
                eh = p[63:32];
                el = p[31:0];
            end
            OP_DIVU: begin
                if (y == 32'h0) begin
                    el = 32'hFFFF_FFFF;
                    eh = x;
                end else begin
                    el = x / y;
                    eh = x % y;
                end
            end
            OP_DIV: begin
                if (y == 32'h0) begin
                    el = 32'hFFFF_FFFF;
                    eh = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000;
                    eh = 32'h0;
                end else begin
                    ix = $signed(x);
                    iy = $signed(y);
                    el = 32'(ix / iy);
                    eh = 32'(ix % iy);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        op = 7'd0;
        a = 32'h0;
        b = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total++;
        if ({hi, lo, busy, done, req_ready} !== {64'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b ready=%b, want 0 0 0 0 1",
                     hi, lo, busy, done, req_ready);
        end
    endtask

    // Issues one mult/div at a negedge and follows it to completion.  With
    // intrude set, an MTHI is presented through the whole busy window.
    task automatic run_md(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit intrude, input string nm);
        logic [31:0] eh, el, h0, l0;
        int  bc = 0;
        int  dc = 0;
        bit  held = 1'b1;
        bit  seen = 1'b0;
        model(o, x, y, eh, el);
        h0 = hi;
        l0 = lo;
        req_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (busy && (hi !== h0 || lo !== l0 || req_ready !== 1'b0)) held = 1'b0;
            if (done) begin
                seen = 1'b1;
                dc++;
                total++;
                if (hi !== eh || lo !== el) begin
                    bad++;
                    $display("FAIL %s result: hi=%h lo=%h, want hi=%h lo=%h", nm, hi, lo, eh, el);
                end
                total++;
                if (busy !== 1'b0 || req_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL %s idle at done: busy=%b ready=%b, want 0 1", nm, busy, req_ready);
                end
            end
            req_valid = intrude && !seen;
            op = intrude ? 7'(OP_MTHI) : 7'($urandom_range(0, 127));
            a  = intrude ? 32'hAAAA_5555 : $urandom;
            b  = $urandom;
        end
        req_valid = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: done=0 after 40 cycles, want pulse", nm);
        end
        total++;
        if (bc != 33) begin
            bad++;
            $display("FAIL %s busy cycles: got %0d, want 33", nm, bc);
        end
        total++;
        if (!held) begin
            bad++;
            $display("FAIL %s hold: hi/lo or ready changed during busy, want stable", nm);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done width: done=%b one cycle later, want 0", nm, done);
        end
    endtask

    task automatic test_directed();
        run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_md(OP_MULT,  32'hFFFF_FFFD, 32'd5,         1'b0, "mult_neg");
        run_md(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, "div_neg");
        run_md(OP_DIVU,  32'd100,       32'd7,         1'b0, "divu_100_7");
        run_md(OP_DIVU,  32'h0000_1234, 32'd0,         1'b0, "divu_by0");
        run_md(OP_DIV,   32'hFFFF_FF00, 32'd0,         1'b0, "div_by0_neg");
        run_md(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    endtask

    task automatic test_busy_ignore();
        run_md(OP_DIVU, 32'd1000, 32'd33, 1'b1, "mthi_mid_div");
        total++;
        if (hi === 32'hAAAA_5555) begin
            bad++;
            $display("FAIL mthi_mid_div leak: hi=%h, want remainder %h", hi, 32'd1000 % 32'd33);
        end
    endtask

    task automatic test_mtlo_mthi();
        logic [31:0] h0, v1, v2;
        h0 = hi;
        req_valid = 1'b1;
        op = OP_MTLO;
        a = 32'h77;
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (lo !== 32'h77 || hi !== h0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mtlo: lo=%h hi=%h done=%b busy=%b, want lo=77 hi=%h 0 0", lo, hi, done, busy, h0);
        end
        v1 = $urandom;
        v2 = $urandom;
        req_valid = 1'b1;
        op = OP_MTHI;
        a = v1;
        @(negedge clk);
        op = OP_MTLO;
        a = v2;
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (hi !== v1 || lo !== v2 || done !== 1'b0) begin
            bad++;
            $display("FAIL mthi_mtlo_b2b: hi=%h lo=%h done=%b, want %h %h 0", hi, lo, done, v1, v2);
        end
    endtask

    task automatic test_bad_op();
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        req_valid = 1'b1;
        op = 7'd0;
        a = 32'h1357_9BDF;
        b = 32'h3;
        @(negedge clk);
        op = 7'd127;
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (hi !== h0 || lo !== l0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL bad_op: hi=%h lo=%h busy=%b done=%b, want %h %h 0 0", hi, lo, busy, done, h0, l0);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [4];
        logic [31:0] x, y;
        ops[0] = OP_MULT;
        ops[1] = OP_MULTU;
        ops[2] = OP_DIV;
        ops[3] = OP_DIVU;
        for (int n = 0; n < 12; n++) begin
            x = $urandom;
            y = $urandom;
            if (n % 4 == 3) y = y >> $urandom_range(8, 31);
            if (n == 10) y = 32'h0;
            run_md(ops[n % 4], x, y, 1'b0, $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_reset_mid_op();
        bit dseen = 1'b0;
        req_valid = 1'b1;
        op = OP_MTHI;
        a = 32'hDEAD_BEEF;
        @(negedge clk);
        op = OP_MULTU;
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_op: busy=%b hi=%h lo=%h done=%b ready=%b, want 0 0 0 0 1",
                     busy, hi, lo, done, req_ready);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dseen = 1'b1;
        end
        total++;
        if (dseen) begin
            bad++;
            $display("FAIL reset_abort: done/busy seen after abort, want none");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_mtlo_mthi();
        test_bad_op();
        test_random();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
